// File: rtl/acq_mem_arbiter.sv
// Two-port (host A / acquisition B) arbiter onto one shared memory bus.
// Each port has a one-entry request slot; grants are round-robin, with a per-access timeout.
module acq_mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        Clk,
    input  logic        rst_n,
    input  logic [16:1] a_Addr,
    input  logic [15:0] a_WrData,
    input  logic        a_RdMem,
    input  logic        a_WrMem,
    output logic [15:0] a_RdData,
    output logic        a_RdDone,
    output logic        a_WrDone,
    input  logic [16:1] b_Addr,
    input  logic [15:0] b_WrData,
    input  logic        b_RdMem,
    input  logic        b_WrMem,
    output logic [15:0] b_RdData,
    output logic        b_RdDone,
    output logic        b_WrDone,
    output logic [16:1] m_Addr,
    output logic [15:0] m_WrData,
    output logic        m_RdMem,
    output logic        m_WrMem,
    input  logic [15:0] m_RdData,
    input  logic        m_RdDone,
    input  logic        m_WrDone,
    output logic        timeout_o,
    output logic        overrun_o,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t      state, state_nx;
    logic        a_vld, a_wr, b_vld, b_wr;
    logic [16:1] a_adr, b_adr;
    logic [15:0] a_dat, b_dat;
    logic        gnt, gnt_wr, ptr;
    logic [15:0] cnt;
    logic        a_stb, b_stb, pick, start, accept, tmo, finish;

    assign a_stb  = a_RdMem | a_WrMem;
    assign b_stb  = b_RdMem | b_WrMem;
    assign pick   = (a_vld & b_vld) ? ptr : b_vld;
    assign start  = (state == IDLE) && (a_vld || b_vld);
    assign accept = ((state == ISSUE) || (state == WAIT)) && (gnt_wr ? m_WrDone : m_RdDone);
    assign tmo    = (state == WAIT) && !accept && (cnt == TO_LAST);
    assign finish = accept || tmo;

    assign m_RdMem   = (state == ISSUE) && !gnt_wr;
    assign m_WrMem   = (state == ISSUE) && gnt_wr;
    assign state_dbg = state;

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = ISSUE;
            ISSUE:   state_nx = accept ? IDLE : WAIT;
            WAIT:    if (finish) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Request slots: a strobe is taken only into an empty slot; completion frees it.
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            a_vld <= 1'b0; a_wr <= 1'b0; a_adr <= '0; a_dat <= '0;
            b_vld <= 1'b0; b_wr <= 1'b0; b_adr <= '0; b_dat <= '0;
            overrun_o <= 1'b0;
        end else begin
            overrun_o <= (a_stb && a_vld) || (b_stb && b_vld);
            if (finish && !gnt) begin
                a_vld <= 1'b0;
            end else if (a_stb && !a_vld) begin
                a_vld <= 1'b1;
                a_wr  <= a_WrMem && !a_RdMem;
                a_adr <= a_Addr;
                a_dat <= a_WrData;
            end
            if (finish && gnt) begin
                b_vld <= 1'b0;
            end else if (b_stb && !b_vld) begin
                b_vld <= 1'b1;
                b_wr  <= b_WrMem && !b_RdMem;
                b_adr <= b_Addr;
                b_dat <= b_WrData;
            end
        end
    end

    // The round-robin pointer moves only on contested grants, so back-to-back
    // collisions alternate regardless of uncontested traffic in between.
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt <= 1'b0; gnt_wr <= 1'b0; ptr <= 1'b0;
            m_Addr <= '0; m_WrData <= '0; cnt <= '0;
        end else begin
            if (start) begin
                gnt      <= pick;
                gnt_wr   <= pick ? b_wr : a_wr;
                m_Addr   <= pick ? b_adr : a_adr;
                m_WrData <= pick ? b_dat : a_dat;
                if (a_vld && b_vld) ptr <= ~pick;
            end
            if (state == ISSUE)             cnt <= '0;
            else if (state == WAIT && !accept) cnt <= cnt + 16'd1;
        end
    end

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            a_RdDone <= 1'b0; a_WrDone <= 1'b0; a_RdData <= '0;
            b_RdDone <= 1'b0; b_WrDone <= 1'b0; b_RdData <= '0;
            timeout_o <= 1'b0;
        end else begin
            a_RdDone  <= finish && !gnt && !gnt_wr;
            a_WrDone  <= finish && !gnt && gnt_wr;
            b_RdDone  <= finish && gnt && !gnt_wr;
            b_WrDone  <= finish && gnt && gnt_wr;
            timeout_o <= tmo;
            if (finish && !gnt && !gnt_wr) a_RdData <= accept ? m_RdData : 16'hFFFF;
            if (finish && gnt && !gnt_wr)  b_RdData <= accept ? m_RdData : 16'hFFFF;
        end
    end

endmodule

// File: tb/tb_acq_mem_arbiter.sv
// Directed bench for acq_mem_arbiter (TIMEOUT=4): write, contention, read data,
// timeout, overrun, back-to-back strobe on done, and mid-access reset.
module tb_acq_mem_arbiter;

  logic        Clk = 1'b0;
  logic        rst_n;
  logic [16:1] a_Addr, b_Addr;
  logic [15:0] a_WrData, b_WrData;
  logic        a_RdMem, a_WrMem, b_RdMem, b_WrMem;
  logic [15:0] a_RdData, b_RdData;
  logic        a_RdDone, a_WrDone, b_RdDone, b_WrDone;
  logic [16:1] m_Addr;
  logic [15:0] m_WrData, m_RdData;
  logic        m_RdMem, m_WrMem, m_RdDone, m_WrDone;
  logic        timeout_o, overrun_o;
  logic [1:0]  state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  acq_mem_arbiter #(.TIMEOUT(4)) dut (
    .Clk(Clk), .rst_n(rst_n),
    .a_Addr(a_Addr), .a_WrData(a_WrData), .a_RdMem(a_RdMem), .a_WrMem(a_WrMem),
    .a_RdData(a_RdData), .a_RdDone(a_RdDone), .a_WrDone(a_WrDone),
    .b_Addr(b_Addr), .b_WrData(b_WrData), .b_RdMem(b_RdMem), .b_WrMem(b_WrMem),
    .b_RdData(b_RdData), .b_RdDone(b_RdDone), .b_WrDone(b_WrDone),
    .m_Addr(m_Addr), .m_WrData(m_WrData), .m_RdMem(m_RdMem), .m_WrMem(m_WrMem),
    .m_RdData(m_RdData), .m_RdDone(m_RdDone), .m_WrDone(m_WrDone),
    .timeout_o(timeout_o), .overrun_o(overrun_o), .state_dbg(state_dbg)
  );

  always #5 Clk = ~Clk;

  // Advance to just after the next rising edge: inputs for the new cycle are
  // driven here and registered outputs of that cycle are sampled here.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    a_RdMem = 0; a_WrMem = 0; b_RdMem = 0; b_WrMem = 0;
    m_RdDone = 0; m_WrDone = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; idle_inputs();
    a_Addr = '0; b_Addr = '0; a_WrData = '0; b_WrData = '0; m_RdData = '0;
    #1;
    chk("rst_state", 16'(state_dbg), 16'd0);
    chk("rst_m_addr", m_Addr, 16'h0000);
    chk("rst_strobes", {14'd0, m_RdMem, m_WrMem}, 16'd0);
    chk("rst_dones", {12'd0, a_RdDone, a_WrDone, b_RdDone, b_WrDone}, 16'd0);
    tick(); tick();
    rst_n = 1;
    tick();

    // Single write, strobe in cycle 0.
    a_WrMem = 1; a_Addr = 16'h0010; a_WrData = 16'hA5A5;
    tick(); idle_inputs();                                   // cycle 1
    chk("wr_c1_mwr", 16'(m_WrMem), 16'd0);
    tick();                                                  // cycle 2
    chk("wr_c2_mwr", 16'(m_WrMem), 16'd1);
    chk("wr_c2_mrd", 16'(m_RdMem), 16'd0);
    chk("wr_c2_addr", m_Addr, 16'h0010);
    chk("wr_c2_data", m_WrData, 16'hA5A5);
    tick(); m_WrDone = 1;                                    // cycle 3
    chk("wr_c3_mwr", 16'(m_WrMem), 16'd0);
    chk("wr_c3_addr_hold", m_Addr, 16'h0010);
    chk("wr_c3_done_early", 16'(a_WrDone), 16'd0);
    tick(); idle_inputs();                                   // cycle 4
    chk("wr_c4_awrdone", 16'(a_WrDone), 16'd1);
    chk("wr_c4_bwrdone", 16'(b_WrDone), 16'd0);
    chk("wr_c4_state", 16'(state_dbg), 16'd0);
    tick();
    chk("wr_c5_awrdone", 16'(a_WrDone), 16'd0);

    // Simultaneous reads: A first after reset.
    a_RdMem = 1; a_Addr = 16'h0100; b_RdMem = 1; b_Addr = 16'h0200;
    tick(); idle_inputs();
    tick();
    chk("rr1_first_addr", m_Addr, 16'h0100);
    chk("rr1_first_rd", 16'(m_RdMem), 16'd1);
    m_RdDone = 1; m_RdData = 16'h1111;                       // done accepted in ISSUE
    tick(); idle_inputs();
    chk("rr1_a_done", 16'(a_RdDone), 16'd1);
    chk("rr1_a_data", a_RdData, 16'h1111);
    chk("rr1_b_done0", 16'(b_RdDone), 16'd0);
    tick();
    chk("rr1_second_addr", m_Addr, 16'h0200);
    chk("rr1_second_rd", 16'(m_RdMem), 16'd1);
    m_RdDone = 1; m_RdData = 16'h2222;
    tick(); idle_inputs();
    chk("rr1_b_done", 16'(b_RdDone), 16'd1);
    chk("rr1_b_data", b_RdData, 16'h2222);
    chk("rr1_a_hold", a_RdData, 16'h1111);

    // Repeat contention: B first this time.
    a_RdMem = 1; a_Addr = 16'h0300; b_RdMem = 1; b_Addr = 16'h0400;
    tick(); idle_inputs();
    tick();
    chk("rr2_first_addr", m_Addr, 16'h0400);
    m_RdDone = 1; m_RdData = 16'h4444;
    tick(); idle_inputs();
    chk("rr2_b_done", 16'(b_RdDone), 16'd1);
    chk("rr2_b_data", b_RdData, 16'h4444);
    tick();
    chk("rr2_second_addr", m_Addr, 16'h0300);
    m_RdDone = 1; m_RdData = 16'h3333;
    tick(); idle_inputs();
    chk("rr2_a_done", 16'(a_RdDone), 16'd1);
    chk("rr2_a_data", a_RdData, 16'h3333);

    // B read with a wrong-direction done first (ignored).
    tick();
    b_RdMem = 1; b_Addr = 16'h1234;
    tick(); idle_inputs();
    tick();
    chk("rd_issue", 16'(m_RdMem), 16'd1);
    m_WrDone = 1; m_RdData = 16'h0BAD;
    tick(); idle_inputs();
    chk("rd_wrongdir_state", 16'(state_dbg), 16'd2);
    chk("rd_wrongdir_done", 16'(b_RdDone), 16'd0);
    m_RdDone = 1; m_RdData = 16'hBEEF;
    tick(); idle_inputs();
    chk("rd_b_done", 16'(b_RdDone), 16'd1);
    chk("rd_b_data", b_RdData, 16'hBEEF);
    chk("rd_a_done0", 16'(a_RdDone), 16'd0);
    chk("rd_timeout0", 16'(timeout_o), 16'd0);

    // Timeout on A read: ISSUE, then 4 WAIT cycles, completion pulse after.
    tick();
    a_RdMem = 1; a_Addr = 16'h0042;
    tick(); idle_inputs();
    tick();
    chk("to_issue", 16'(state_dbg), 16'd1);
    tick(); tick(); tick(); tick();
    chk("to_last_wait", 16'(state_dbg), 16'd2);
    chk("to_no_done_yet", 16'(a_RdDone), 16'd0);
    tick();
    chk("to_a_done", 16'(a_RdDone), 16'd1);
    chk("to_a_data", a_RdData, 16'hFFFF);
    chk("to_flag", 16'(timeout_o), 16'd1);
    chk("to_state", 16'(state_dbg), 16'd0);
    tick();
    chk("to_flag_pulse", 16'(timeout_o), 16'd0);

    // Overrun: second A write during WAIT is dropped.
    a_WrMem = 1; a_Addr = 16'h0050; a_WrData = 16'h1111;
    tick(); idle_inputs();
    tick();
    chk("ov_issue", 16'(m_WrMem), 16'd1);
    tick();
    a_WrMem = 1; a_Addr = 16'h0060; a_WrData = 16'h2222;
    tick(); idle_inputs();
    chk("ov_flag", 16'(overrun_o), 16'd1);
    chk("ov_addr_kept", m_Addr, 16'h0050);
    chk("ov_data_kept", m_WrData, 16'h1111);
    m_WrDone = 1;
    tick(); idle_inputs();
    chk("ov_done", 16'(a_WrDone), 16'd1);
    chk("ov_flag_pulse", 16'(overrun_o), 16'd0);
    a_WrMem = 1; a_Addr = 16'h0080; a_WrData = 16'h8888;   // strobe in done cycle
    tick(); idle_inputs();
    chk("ov_no_second_wr", 16'(m_WrMem), 16'd0);
    chk("ov_accept_no_ovr", 16'(overrun_o), 16'd0);
    tick();
    chk("b2b_issue", 16'(m_WrMem), 16'd1);
    chk("b2b_addr", m_Addr, 16'h0080);
    chk("b2b_data", m_WrData, 16'h8888);
    m_WrDone = 1;
    tick(); idle_inputs();
    chk("b2b_done", 16'(a_WrDone), 16'd1);

    // Reset during WAIT aborts without a done pulse.
    tick();
    a_RdMem = 1; a_Addr = 16'h0070;
    tick(); idle_inputs();
    tick(); tick();
    chk("rstw_state", 16'(state_dbg), 16'd2);
    rst_n = 0;
    #1;
    chk("rstw_state0", 16'(state_dbg), 16'd0);
    chk("rstw_addr0", m_Addr, 16'h0000);
    chk("rstw_rddata0", a_RdData, 16'h0000);
    tick();
    rst_n = 1;
    tick();
    chk("rstw_no_done", 16'(a_RdDone), 16'd0);
    tick();
    chk("rstw_idle", 16'(state_dbg), 16'd0);
    chk("rstw_no_issue", 16'(m_RdMem), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
